logic_gate_exerciser: RTL
=========================

LOGIC_GATE_EXERCISER -- requirements
Module: logic_gate_exerciser

Interface
REQ-001: The block SHALL have parameter ROUNDS, default 4, giving the number of full passes over the 4 input vectors per run (legal range 1..255).
REQ-002: The block SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-003: The block SHALL use a single clock, clk, with all state updating on its rising edge; reset rst is synchronous and active-high.
REQ-004: clk  input  1  system clock.
REQ-005: rst  input  1  synchronous active-high reset.
REQ-006: start  input  1  run request, sampled only in IDLE or DONE.
REQ-007: a, b  output  1 each  registered stimulus driven into the downstream gate stage.
REQ-008: and_gate, or_gate, not_gate, nand_gate, nor_gate, xor_gate, xnor_gate  input  1 each  gate-stage responses to a/b.
REQ-009: busy  output  1  high in DRIVE or SAMPLE.
REQ-010: done  output  1  high while in DONE.
REQ-011: pass  output  1  high in DONE when err_cnt==0; low otherwise.
REQ-012: err_cnt  output  CNT_W  count of failing vectors in the current/last run.
REQ-013: fail_valid  output  1  a failure has been latched this run.
REQ-014: fail_vec  output  2  {a,b} of the first failing vector.
REQ-015: fail_mask  output  7  per-gate mismatch bits of the first failure, bit order {xnor,xor,nor,nand,not,or,and} = [6:0].

Function
REQ-016: The FSM SHALL have states IDLE, DRIVE, SAMPLE, DONE.
REQ-017: In IDLE or DONE, start=1 SHALL move to DRIVE next cycle and clear vec, round, err_cnt, fail_valid, fail_vec, fail_mask.
REQ-018: start SHALL be ignored in DRIVE and SAMPLE.
REQ-019: In DRIVE, a SHALL be set to vec[1] and b to vec[0] (registered, visible the cycle after DRIVE), and the FSM SHALL go to SAMPLE.
REQ-020: In SAMPLE, a/b SHALL stay stable, and expected values SHALL be computed from the registered a/b: and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
REQ-021: In SAMPLE, mask = expected XOR observed (7 bits); if mask!=0, err_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-022: On the first nonzero mask of a run, fail_vec/fail_mask SHALL latch and fail_valid SHALL go 1; later failures SHALL NOT overwrite them.
REQ-023: After SAMPLE, vec SHALL increment modulo 4; on wrap 3->0, round SHALL increment.
REQ-024: After SAMPLE with vec==3 and round==ROUNDS-1, the FSM SHALL go to DONE; otherwise it SHALL return to DRIVE.
REQ-025: Each vector SHALL take exactly 2 cycles; DONE SHALL be entered exactly 8*ROUNDS cycles after the cycle start is accepted.
REQ-026: DONE SHALL hold done=1 and all results stable until start or rst.
REQ-027: start asserted in DONE SHALL clear done and pass in the next cycle, when DRIVE is entered.

Reset
REQ-028: rst=1 SHALL, at the next edge and from any state including mid-run, force IDLE with a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_vec=0, fail_mask=0.
REQ-029: rst SHALL take priority over start in the same cycle.

Verification
REQ-030: Correct gate model, ROUNDS=4, start pulse -> a/b sequence 00,01,10,11 repeated 4 times, 2 cycles each; done at cycle 32; pass=1; err_cnt=0; fail_valid=0.
REQ-031: and_gate stuck at 0, ROUNDS=1 -> done at cycle 8; err_cnt=1; fail_vec=2'b11; fail_mask=7'b0000001; pass=0.
REQ-032: xor_gate inverted, ROUNDS=2 -> err_cnt=8; fail_vec=2'b00; fail_mask=7'b0100000 (first failure retained).
REQ-033: All outputs inverted, CNT_W=2, ROUNDS=4 -> err_cnt saturates at 3; fail_mask=7'b1111111.
REQ-034: rst pulsed in cycle 5 of a run -> all outputs zero next cycle; start pulses during busy are ignored with no restart; start in DONE restarts with cleared counters.

Source files
------------

// File: rtl/logic_gate_exerciser.sv
// Drives the four {a,b} input combinations into an external gate stage for ROUNDS passes.
// It checks all seven gate responses on each vector and records the error count and the first failure.
module logic_gate_exerciser #(
  parameter int unsigned ROUNDS = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             and_gate,
  input  logic             or_gate,
  input  logic             not_gate,
  input  logic             nand_gate,
  input  logic             nor_gate,
  input  logic             xor_gate,
  input  logic             xnor_gate,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec,
  output logic [6:0]       fail_mask
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0]       ROUND_LAST = 8'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ERR_ONE    = CNT_W'(1);

  // Expected responses, bit order {xnor,xor,nor,nand,not,or,and}
  function automatic logic [6:0] gate_model(input logic x, input logic y);
    return {~(x ^ y), x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       vec_r, vec_s;
  logic [7:0]       round_r, round_s;
  logic [CNT_W-1:0] err_s;
  logic             a_s, b_s, busy_s, done_s, pass_s;
  logic             fail_valid_s;
  logic [1:0]       fail_vec_s;
  logic [6:0]       fail_mask_s;
  logic [6:0]       observed_s, mask_s;

  assign observed_s = {xnor_gate, xor_gate, nor_gate, nand_gate, not_gate, or_gate, and_gate};
  assign mask_s     = gate_model(a, b) ^ observed_s;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_s      = state_r;
    vec_s        = vec_r;
    round_s      = round_r;
    err_s        = err_cnt;
    fail_valid_s = fail_valid;
    fail_vec_s   = fail_vec;
    fail_mask_s  = fail_mask;
    a_s          = a;
    b_s          = b;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s      = DRIVE;
          vec_s        = 2'd0;
          round_s      = 8'd0;
          err_s        = '0;
          fail_valid_s = 1'b0;
          fail_vec_s   = 2'd0;
          fail_mask_s  = 7'd0;
        end else begin
          state_s = state_r;
        end
      end
      DRIVE: begin
        a_s     = vec_r[1];
        b_s     = vec_r[0];
        state_s = SAMPLE;
      end
      SAMPLE: begin
        if (mask_s != 7'd0) begin
          err_s = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_ONE;
          if (!fail_valid) begin
            fail_valid_s = 1'b1;
            fail_vec_s   = {a, b};
            fail_mask_s  = mask_s;
          end else begin
            fail_valid_s = fail_valid;
          end
        end else begin
          err_s = err_cnt;
        end
        vec_s = vec_r + 2'd1;
        if (vec_r == 2'd3) begin
          round_s = round_r + 8'd1;
        end else begin
          round_s = round_r;
        end
        if ((vec_r == 2'd3) && (round_r == ROUND_LAST)) begin
          state_s = DONE;
        end else begin
          state_s = DRIVE;
        end
      end
      default: state_s = IDLE;
    endcase
    busy_s = (state_s == DRIVE) || (state_s == SAMPLE);
    done_s = (state_s == DONE);
    pass_s = done_s && (err_s == '0);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      vec_r      <= 2'd0;
      round_r    <= 8'd0;
      a          <= 1'b0;
      b          <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      fail_mask  <= 7'd0;
    end else begin
      state_r    <= state_s;
      vec_r      <= vec_s;
      round_r    <= round_s;
      a          <= a_s;
      b          <= b_s;
      busy       <= busy_s;
      done       <= done_s;
      pass       <= pass_s;
      err_cnt    <= err_s;
      fail_valid <= fail_valid_s;
      fail_vec   <= fail_vec_s;
      fail_mask  <= fail_mask_s;
    end
  end

endmodule
